// File: rtl/ddma_cfg_mc.sv
// ddma_cfg_mc -- multi-channel, multi-PE configuration and dispatch block for the dDMA engines.
//
// Each PE programs a private shadow descriptor per channel over its peripheral port. A GO
// write queues that shadow set in the channel's descriptor FIFO. A per-channel dispatcher
// launches queued descriptors with a toggle start/resp tag handshake.
//
// Ports
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_peri_*               per-PE request: rden, wren, byte addr, wdata, wstrb (wstrb ignored)
//   o_peri_rdata/ready     per-PE read data and one-cycle acknowledge, one cycle after accept
//   o_tag_start_dDMA       per-channel start tag, toggles on each launch
//   i_tag_resp_dDMA        per-channel resp tag, toggled by the engine to match when done
//   o_addr_RAM, o_len_RAM, o_addr_RAM_AIPE, o_len_RAM_AIPE, o_dir
//                          launched descriptor per channel, held until the next launch
//   o_irq                  per-PE completion pulse
//
// Configuration macro DDMA_CFG_IRQ_EN: when defined, each descriptor records its owning PE
// and completion pulses o_irq[owner]. Otherwise no owner is stored and o_irq is tied 0.
//
// Register map (addr[4:2]), channel = addr[5 +: log2(NUM_CH)]:
//   0 ADDR  1 LEN  2 AADDR  3 ALEN  4 DIR  5 GO  6 STATUS (wr clears ovf)  7 DONECLR
module ddma_cfg_mc #(
   parameter int unsigned NUM_PE     = 3,
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned DESC_DEPTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [NUM_PE-1:0]     i_peri_rden,
   input  logic [NUM_PE-1:0]     i_peri_wren,
   input  logic [NUM_PE*32-1:0]  i_peri_addr,
   input  logic [NUM_PE*32-1:0]  i_peri_wdata,
   input  logic [NUM_PE*4-1:0]   i_peri_wstrb,
   output logic [NUM_PE*32-1:0]  o_peri_rdata,
   output logic [NUM_PE-1:0]     o_peri_ready,
   output logic [NUM_CH-1:0]     o_tag_start_dDMA,
   input  logic [NUM_CH-1:0]     i_tag_resp_dDMA,
   output logic [NUM_CH*32-1:0]  o_addr_RAM,
   output logic [NUM_CH*16-1:0]  o_len_RAM,
   output logic [NUM_CH*32-1:0]  o_addr_RAM_AIPE,
   output logic [NUM_CH*16-1:0]  o_len_RAM_AIPE,
   output logic [NUM_CH-1:0]     o_dir,
   output logic [NUM_PE-1:0]     o_irq
);

   localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned PEW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
   localparam int unsigned PW  = $clog2(DESC_DEPTH);
   localparam int unsigned CW  = $clog2(DESC_DEPTH) + 1;

   typedef struct packed {
`ifdef DDMA_CFG_IRQ_EN
      logic [PEW-1:0] owner;
`endif
      logic           dir;
      logic [15:0]    alen;
      logic [31:0]    aaddr;
      logic [15:0]    len;
      logic [31:0]    addr;
   } desc_t;

   // per-PE decode
   logic [CHW-1:0] pe_ch  [NUM_PE];
   logic [2:0]     pe_reg [NUM_PE];
   logic [31:0]    pe_wd  [NUM_PE];

   // shadow registers per (PE, channel)
   logic [31:0] sh_addr_q  [NUM_PE][NUM_CH];
   logic [15:0] sh_len_q   [NUM_PE][NUM_CH];
   logic [31:0] sh_aaddr_q [NUM_PE][NUM_CH];
   logic [15:0] sh_alen_q  [NUM_PE][NUM_CH];
   logic        sh_dir_q   [NUM_PE][NUM_CH];

   // arbitration
   logic [PEW-1:0]    rr_q [NUM_CH];
   logic [PEW-1:0]    rr_d [NUM_CH];
   logic [NUM_PE-1:0] gnt, acc;
   logic              found;
   int unsigned       t;
   logic [PEW-1:0]    idx;

   // per-channel queue and dispatcher
   desc_t           fifo_q [NUM_CH][DESC_DEPTH];
   logic [PW-1:0]   wp_q   [NUM_CH];
   logic [PW-1:0]   rp_q   [NUM_CH];
   logic [CW-1:0]   cnt_q  [NUM_CH];
   desc_t           la_q   [NUM_CH];
   logic [7:0]      done_q [NUM_CH];
   logic [NUM_CH-1:0] tag_q, busy_q, ovf_q;
   logic [NUM_CH-1:0] push_v, push_ok, pop, idle, full, drop, done, ovf_clr, done_clr;
   desc_t           push_d [NUM_CH];
   desc_t           gd;

   logic [31:0]       rdata_q [NUM_PE];
   logic [31:0]       rdata_d [NUM_PE];
   logic [NUM_PE-1:0] ready_q;

   logic unused_ok;
   assign unused_ok = ^{i_peri_wstrb, i_peri_addr};

   always_comb begin
      for (int unsigned p = 0; p < NUM_PE; p++) begin
         pe_ch[p]  = i_peri_addr[p*32+5 +: CHW] & CHW'(NUM_CH - 1);
         pe_reg[p] = i_peri_addr[p*32+2 +: 3];
         pe_wd[p]  = i_peri_wdata[p*32 +: 32];
      end
   end

   // Round-robin per channel: scan PEs starting at the pointer, first writer of this channel wins.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      t     = 0;
      idx   = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         rr_d[c] = rr_q[c];
         found   = 1'b0;
         for (int unsigned k = 0; k < NUM_PE; k++) begin
            t = 32'(rr_q[c]) + k;
            if (t >= NUM_PE) t = t - NUM_PE;
            idx = PEW'(t);
            if (!found && i_peri_wren[idx] && (pe_ch[idx] == CHW'(c))) begin
               found    = 1'b1;
               gnt[idx] = 1'b1;
               rr_d[c]  = (t == NUM_PE - 1) ? '0 : PEW'(t + 1);
            end
         end
      end
   end

   assign acc = gnt | (i_peri_rden & ~i_peri_wren);

   // Channel-side effects of granted writes; at most one winner per channel.
   always_comb begin
      push_v   = '0;
      ovf_clr  = '0;
      done_clr = '0;
      gd       = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) push_d[c] = '0;
      for (int unsigned p = 0; p < NUM_PE; p++) begin
         if (gnt[p]) begin
            case (pe_reg[p])
               3'd5: begin
                  gd       = '0;
                  gd.addr  = sh_addr_q[p][pe_ch[p]];
                  gd.len   = sh_len_q[p][pe_ch[p]];
                  gd.aaddr = sh_aaddr_q[p][pe_ch[p]];
                  gd.alen  = sh_alen_q[p][pe_ch[p]];
                  gd.dir   = sh_dir_q[p][pe_ch[p]];
`ifdef DDMA_CFG_IRQ_EN
                  gd.owner = PEW'(p);
`endif
                  push_v[pe_ch[p]] = 1'b1;
                  push_d[pe_ch[p]] = gd;
               end
               3'd6:    ovf_clr[pe_ch[p]]  = 1'b1;
               3'd7:    done_clr[pe_ch[p]] = 1'b1;
               default: ;
            endcase
         end
      end
   end

   // A full FIFO still takes a GO when a pop frees a slot in the same cycle.
   always_comb begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         idle[c]    = (tag_q[c] == i_tag_resp_dDMA[c]);
         pop[c]     = idle[c] && (cnt_q[c] != '0);
         full[c]    = (cnt_q[c] == CW'(DESC_DEPTH));
         drop[c]    = push_v[c] && full[c] && !pop[c];
         push_ok[c] = push_v[c] && !drop[c];
         done[c]    = busy_q[c] && idle[c];
      end
   end

   always_comb begin
      for (int unsigned p = 0; p < NUM_PE; p++) begin
         rdata_d[p] = '0;
         if (i_peri_rden[p] && !i_peri_wren[p]) begin
            case (pe_reg[p])
               3'd0: rdata_d[p] = sh_addr_q[p][pe_ch[p]];
               3'd1: rdata_d[p] = {16'b0, sh_len_q[p][pe_ch[p]]};
               3'd2: rdata_d[p] = sh_aaddr_q[p][pe_ch[p]];
               3'd3: rdata_d[p] = {16'b0, sh_alen_q[p][pe_ch[p]]};
               3'd4: rdata_d[p] = {31'b0, sh_dir_q[p][pe_ch[p]]};
               3'd6: rdata_d[p] = {16'b0, done_q[pe_ch[p]], ovf_q[pe_ch[p]], full[pe_ch[p]],
                                   ~idle[pe_ch[p]], 5'(cnt_q[pe_ch[p]])};
               default: rdata_d[p] = '0;
            endcase
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ready_q <= '0;
         tag_q   <= '0;
         busy_q  <= '0;
         ovf_q   <= '0;
         for (int unsigned p = 0; p < NUM_PE; p++) begin
            rdata_q[p] <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
               sh_addr_q[p][c]  <= '0;
               sh_len_q[p][c]   <= '0;
               sh_aaddr_q[p][c] <= '0;
               sh_alen_q[p][c]  <= '0;
               sh_dir_q[p][c]   <= 1'b0;
            end
         end
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            rr_q[c]   <= '0;
            wp_q[c]   <= '0;
            rp_q[c]   <= '0;
            cnt_q[c]  <= '0;
            la_q[c]   <= '0;
            done_q[c] <= '0;
            for (int unsigned d = 0; d < DESC_DEPTH; d++) fifo_q[c][d] <= '0;
         end
      end else begin
         ready_q <= acc;
         for (int unsigned p = 0; p < NUM_PE; p++) begin
            rdata_q[p] <= rdata_d[p];
            if (gnt[p]) begin
               case (pe_reg[p])
                  3'd0:    sh_addr_q[p][pe_ch[p]]  <= {pe_wd[p][31:2], 2'b0};
                  3'd1:    sh_len_q[p][pe_ch[p]]   <= pe_wd[p][15:0];
                  3'd2:    sh_aaddr_q[p][pe_ch[p]] <= {pe_wd[p][31:4], 4'b0};
                  3'd3:    sh_alen_q[p][pe_ch[p]]  <= {pe_wd[p][15:4], 4'b0};
                  3'd4:    sh_dir_q[p][pe_ch[p]]   <= pe_wd[p][0];
                  default: ;
               endcase
            end
         end
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            rr_q[c] <= rr_d[c];
            if (push_ok[c]) begin
               fifo_q[c][wp_q[c]] <= push_d[c];
               wp_q[c]            <= wp_q[c] + 1'b1;
            end
            if (pop[c]) begin
               la_q[c]  <= fifo_q[c][rp_q[c]];
               rp_q[c]  <= rp_q[c] + 1'b1;
               tag_q[c] <= ~tag_q[c];
            end
            cnt_q[c]  <= cnt_q[c] + CW'(push_ok[c]) - CW'(pop[c]);
            busy_q[c] <= ~idle[c];
            if (done_clr[c])  done_q[c] <= '0;
            else if (done[c]) done_q[c] <= done_q[c] + 8'd1;
            if (drop[c])         ovf_q[c] <= 1'b1;
            else if (ovf_clr[c]) ovf_q[c] <= 1'b0;
         end
      end
   end

`ifdef DDMA_CFG_IRQ_EN
   logic [NUM_PE-1:0] irq_q, irq_d;

   always_comb begin
      irq_d = '0;
      for (int unsigned c = 0; c < NUM_CH; c++)
         if (done[c]) irq_d[la_q[c].owner] = 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) irq_q <= '0;
      else       irq_q <= irq_d;
   end

   assign o_irq = irq_q;
`else
   assign o_irq = '0;
`endif

   always_comb begin
      o_peri_rdata = '0;
      for (int unsigned p = 0; p < NUM_PE; p++) o_peri_rdata[p*32 +: 32] = rdata_q[p];
      o_addr_RAM      = '0;
      o_len_RAM       = '0;
      o_addr_RAM_AIPE = '0;
      o_len_RAM_AIPE  = '0;
      o_dir           = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         o_addr_RAM[c*32 +: 32]      = la_q[c].addr;
         o_len_RAM[c*16 +: 16]       = la_q[c].len;
         o_addr_RAM_AIPE[c*32 +: 32] = la_q[c].aaddr;
         o_len_RAM_AIPE[c*16 +: 16]  = la_q[c].alen;
         o_dir[c]                    = la_q[c].dir;
      end
   end

   assign o_peri_ready     = ready_q;
   assign o_tag_start_dDMA = tag_q;

endmodule

// File: tb/tb_ddma_cfg_mc.sv
// Self-checking bench for ddma_cfg_mc (NUM_PE=3, NUM_CH=2, DESC_DEPTH=4).
module tb_ddma_cfg_mc;
   localparam int NPE = 3;
   localparam int NCH = 2;
`ifdef DDMA_CFG_IRQ_EN
   localparam bit IRQ_ON = 1'b1;
`else
   localparam bit IRQ_ON = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst;
   logic [NPE-1:0]     rden, wren;
   logic [NPE*32-1:0]  addr, wdata, rdata;
   logic [NPE*4-1:0]   wstrb;
   logic [NPE-1:0]     ready, irq;
   logic [NCH-1:0]     tag_start, tag_resp;
   logic [NCH*32-1:0]  addr_ram, addr_aipe;
   logic [NCH*16-1:0]  len_ram, len_aipe;
   logic [NCH-1:0]     dir;

   logic        pe_rden  [NPE];
   logic        pe_wren  [NPE];
   logic [31:0] pe_addr  [NPE];
   logic [31:0] pe_wdata [NPE];

   always #5 clk = ~clk;

   always_comb begin
      rden = '0; wren = '0; addr = '0; wdata = '0;
      for (int p = 0; p < NPE; p++) begin
         rden[p] = pe_rden[p];
         wren[p] = pe_wren[p];
         addr[p*32 +: 32]  = pe_addr[p];
         wdata[p*32 +: 32] = pe_wdata[p];
      end
   end
   assign wstrb = '1;

   ddma_cfg_mc #(.NUM_PE(3), .NUM_CH(2), .DESC_DEPTH(4)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_peri_rden(rden), .i_peri_wren(wren), .i_peri_addr(addr),
      .i_peri_wdata(wdata), .i_peri_wstrb(wstrb),
      .o_peri_rdata(rdata), .o_peri_ready(ready),
      .o_tag_start_dDMA(tag_start), .i_tag_resp_dDMA(tag_resp),
      .o_addr_RAM(addr_ram), .o_len_RAM(len_ram),
      .o_addr_RAM_AIPE(addr_aipe), .o_len_RAM_AIPE(len_aipe),
      .o_dir(dir), .o_irq(irq)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard of acknowledges in expected order
   typedef struct {
      int          pe;
      logic [31:0] data;
      bit          chk;
   } exp_t;
   exp_t sbq[$];

   always @(negedge clk) begin
      exp_t e;
      for (int p = 0; p < NPE; p++) begin
         if (ready[p]) begin
            n_cmp++;
            if (sbq.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_ready: pe%0d acknowledged with nothing outstanding", p);
            end else begin
               e = sbq.pop_front();
               if (e.pe != p || (e.chk && rdata[p*32 +: 32] !== e.data)) begin
                  n_err++;
                  $display("FAIL ack_pe%0d: got pe%0d rdata %h, expected pe%0d rdata %h",
                           p, p, rdata[p*32 +: 32], e.pe, e.data);
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Drive one request and hold it until acknowledged (bounded).
   task automatic access(input int p, input bit wr, input int ch, input int rg,
                         input logic [31:0] wd, output int tcyc);
      bit got = 1'b0;
      pe_addr[p]  = 32'(ch * 32 + rg * 4);
      pe_wdata[p] = wd;
      pe_wren[p]  = wr;
      pe_rden[p]  = !wr;
      for (int n = 0; n < 50; n++) begin
         @(posedge clk); #1;
         if (ready[p]) begin got = 1'b1; break; end
      end
      pe_wren[p] = 1'b0;
      pe_rden[p] = 1'b0;
      tcyc = cyc;
      if (!got) begin
         n_cmp++; n_err++;
         $display("FAIL timeout_pe%0d: no ready after 50 cycles, expected ready", p);
      end
   endtask

   task automatic acc1(input int p, input bit wr, input int ch, input int rg,
                       input logic [31:0] wd, input logic [31:0] ex);
      int tc;
      sbq.push_back('{p, ex, !wr});
      access(p, wr, ch, rg, wd, tc);
   endtask

   task automatic resp_toggle(input int c);
      tag_resp[c] = ~tag_resp[c];
      @(posedge clk); #1;
   endtask

   typedef struct {
      int          pe;
      bit          wr;
      int          ch;
      int          rg;
      logic [31:0] wd;
      logic [31:0] ex;
   } vec_t;
   vec_t vt[15];

   int t0, t1, t2;
   logic [NCH-1:0] etag;

   initial begin
      vt[0]  = '{0, 1, 0, 0, 32'h0000_1003, 32'h0};
      vt[1]  = '{0, 0, 0, 0, 32'h0,         32'h0000_1000};
      vt[2]  = '{1, 0, 0, 0, 32'h0,         32'h0};
      vt[3]  = '{0, 1, 0, 2, 32'hABCD_EF7F, 32'h0};
      vt[4]  = '{0, 0, 0, 2, 32'h0,         32'hABCD_EF70};
      vt[5]  = '{2, 1, 1, 3, 32'h1234_5678, 32'h0};
      vt[6]  = '{2, 0, 1, 3, 32'h0,         32'h0000_5670};
      vt[7]  = '{1, 1, 1, 1, 32'hDEAD_BEEF, 32'h0};
      vt[8]  = '{1, 0, 1, 1, 32'h0,         32'h0000_BEEF};
      vt[9]  = '{2, 1, 1, 4, 32'hFFFF_FFFF, 32'h0};
      vt[10] = '{2, 0, 1, 4, 32'h0,         32'h0000_0001};
      vt[11] = '{0, 0, 1, 6, 32'h0,         32'h0};
      vt[12] = '{1, 0, 0, 7, 32'h0,         32'h0};
      vt[13] = '{2, 0, 0, 3, 32'h0,         32'h0};
      vt[14] = '{0, 0, 1, 4, 32'h0,         32'h0};

      for (int p = 0; p < NPE; p++) begin
         pe_rden[p] = 1'b0; pe_wren[p] = 1'b0; pe_addr[p] = '0; pe_wdata[p] = '0;
      end
      rst      = 1'b1;
      tag_resp = '0;
      etag     = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tag",   32'(tag_start), 32'h0);
      chk("rst_addr",  addr_ram[31:0], 32'h0);
      chk("rst_ready", 32'(ready),     32'h0);
      chk("rst_irq",   32'(irq),       32'h0);
      rst = 1'b0;

      // register write / read-back table
      for (int i = 0; i < 15; i++)
         acc1(vt[i].pe, vt[i].wr, vt[i].ch, vt[i].rg, vt[i].wd, vt[i].ex);

      // 1: PE0 launch on ch0
      acc1(0, 1, 0, 1, 32'h0000_0040, 32'h0);
      acc1(0, 1, 0, 4, 32'h0000_0001, 32'h0);
      acc1(0, 1, 0, 5, 32'h0, 32'h0);
      chk("t1_tag_before", 32'(tag_start), 32'(etag));
      @(posedge clk); #1;
      etag[0] = ~etag[0];
      chk("t1_tag_after", 32'(tag_start), 32'(etag));
      chk("t1_addr",  addr_ram[31:0],  32'h0000_1000);
      chk("t1_len",   32'(len_ram[15:0]), 32'h40);
      chk("t1_aaddr", addr_aipe[31:0], 32'hABCD_EF70);
      chk("t1_dir",   32'(dir[0]),     32'h1);
      acc1(0, 0, 0, 6, 32'h0, 32'h0000_0020);
      resp_toggle(0);
      chk("t1_irq", 32'(irq), IRQ_ON ? 32'h1 : 32'h0);
      acc1(0, 0, 0, 6, 32'h0, 32'h0000_0100);

      // 2: three-way contention on ch1, then pointer wrap
      sbq.push_back('{0, 32'h0, 1'b0});
      sbq.push_back('{1, 32'h0, 1'b0});
      sbq.push_back('{2, 32'h0, 1'b0});
      fork
         access(0, 1, 1, 0, 32'h0000_0100, t0);
         access(1, 1, 1, 0, 32'h0000_0200, t1);
         access(2, 1, 1, 0, 32'h0000_0300, t2);
      join
      chk("t2_rr_pe1_next", 32'(t1), 32'(t0 + 1));
      chk("t2_rr_pe2_next", 32'(t2), 32'(t1 + 1));
      sbq.push_back('{0, 32'h0, 1'b0});
      sbq.push_back('{2, 32'h0, 1'b0});
      fork
         access(2, 1, 1, 0, 32'h0000_0600, t2);
         access(0, 1, 1, 0, 32'h0000_0500, t0);
      join
      chk("t2_wrap_pe0_first", 32'(t2), 32'(t0 + 1));
      acc1(0, 0, 1, 0, 32'h0, 32'h0000_0500);
      acc1(1, 0, 1, 0, 32'h0, 32'h0000_0200);
      acc1(2, 0, 1, 0, 32'h0, 32'h0000_0600);

      // 3: stalled ch1, overflow, ordered drain
      for (int k = 0; k < 6; k++) begin
         acc1(1, 1, 1, 0, 32'(32'h2000 + k * 16), 32'h0);
         acc1(1, 1, 1, 5, 32'h0, 32'h0);
      end
      etag[1] = ~etag[1];
      chk("t3_tag", 32'(tag_start), 32'(etag));
      chk("t3_first_addr", addr_ram[63:32], 32'h0000_2000);
      chk("t3_len", 32'(len_ram[31:16]), 32'h0000_BEEF);
      acc1(1, 0, 1, 6, 32'h0, 32'h0000_00E4);
      for (int i = 1; i <= 4; i++) begin
         resp_toggle(1);
         etag[1] = ~etag[1];
         chk("t3_drain_tag",  32'(tag_start), 32'(etag));
         chk("t3_drain_addr", addr_ram[63:32], 32'(32'h2000 + i * 16));
         repeat (2) @(posedge clk);
         #1;
      end
      resp_toggle(1);
      chk("t3_no_launch_tag", 32'(tag_start), 32'(etag));
      chk("t3_hold_addr", addr_ram[63:32], 32'h0000_2040);
      repeat (2) @(posedge clk);
      #1;
      acc1(1, 0, 1, 6, 32'h0, 32'h0000_0580);
      acc1(1, 1, 1, 6, 32'h0, 32'h0);
      acc1(1, 1, 1, 7, 32'h0, 32'h0);
      acc1(1, 0, 1, 6, 32'h0, 32'h0);

      // 4: parallel GOs on different channels
      acc1(1, 1, 0, 0, 32'h0000_3000, 32'h0);
      acc1(2, 1, 1, 0, 32'h0000_4000, 32'h0);
      sbq.push_back('{1, 32'h0, 1'b0});
      sbq.push_back('{2, 32'h0, 1'b0});
      fork
         access(1, 1, 0, 5, 32'h0, t1);
         access(2, 1, 1, 5, 32'h0, t2);
      join
      chk("t4_same_cycle", 32'(t2), 32'(t1));
      @(posedge clk); #1;
      etag = ~etag;
      chk("t4_tags", 32'(tag_start), 32'(etag));
      chk("t4_addr0", addr_ram[31:0],  32'h0000_3000);
      chk("t4_addr1", addr_ram[63:32], 32'h0000_4000);
      chk("t4_len0",  32'(len_ram[15:0]), 32'h0);
      chk("t4_alen1", 32'(len_aipe[31:16]), 32'h0000_5670);
      chk("t4_dir",   32'(dir), 32'h2);
      repeat (2) @(posedge clk);
      #1;
      tag_resp = ~tag_resp;
      @(posedge clk); #1;
      chk("t4_irq", 32'(irq), IRQ_ON ? 32'h6 : 32'h0);
      @(posedge clk); #1;
      chk("t4_irq_clear", 32'(irq), 32'h0);

      // 6: completion pulse to PE2
      acc1(2, 1, 1, 5, 32'h0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      etag[1] = ~etag[1];
      chk("t6_tag", 32'(tag_start), 32'(etag));
      resp_toggle(1);
      chk("t6_irq", 32'(irq), IRQ_ON ? 32'h4 : 32'h0);
      @(posedge clk); #1;
      chk("t6_irq_clear", 32'(irq), 32'h0);

      // 5: reset with ch0 busy and two queued
      for (int k = 0; k < 3; k++) acc1(0, 1, 0, 5, 32'h0, 32'h0);
      acc1(0, 0, 0, 6, 32'h0, 32'h0000_0222);
      rst      = 1'b1;
      tag_resp = '0;
      @(posedge clk); #1;
      chk("t5_tag",   32'(tag_start), 32'h0);
      chk("t5_addr0", addr_ram[31:0], 32'h0);
      chk("t5_addr1", addr_ram[63:32], 32'h0);
      chk("t5_dir",   32'(dir), 32'h0);
      chk("t5_ready", 32'(ready), 32'h0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("t5_no_launch", 32'(tag_start), 32'h0);
      acc1(0, 0, 0, 6, 32'h0, 32'h0);
      acc1(0, 0, 0, 0, 32'h0, 32'h0);

      @(posedge clk); #1;
      chk("sb_drained", 32'(sbq.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish, expected completion");
      $fatal(1, "timeout");
   end
endmodule
